// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: arbitrates fetch/data requests onto the single-port memory with fixed wait states.
// Define MEM_SEQ_RR_EN for round-robin contention; otherwise data always beats fetch.
module mem_access_sequencer #(
  parameter int READ_WAIT  = 3,
  parameter int WRITE_WAIT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Address,
  output logic        MemReadWrite,
  output logic [31:0] WriteDataMem,
  output logic [31:0] rdata,
  output logic        fetch_done,
  output logic        data_done,
  output logic        owner_data,
  output logic        busy,
  output logic [1:0]  State_out
);
  localparam int MAXW = READ_WAIT > WRITE_WAIT ? READ_WAIT : WRITE_WAIT;
  localparam int CW   = $clog2(MAXW + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr, r_wdata, r_rdata;
  logic            r_we, r_owner;
  logic            w_req, w_grant_data, w_last;
  assign w_req  = fetch_req | data_req;
  assign w_last = r_cnt == (r_we ? CW'(WRITE_WAIT - 1) : CW'(READ_WAIT - 1));
`ifdef MEM_SEQ_RR_EN
  logic r_last_owner;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_last_owner <= 1'b1;
    else if (r_state == DONE) r_last_owner <= r_owner;
  assign w_grant_data = data_req & (~fetch_req | ~r_last_owner);
`else
  assign w_grant_data = data_req;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE   ? (w_req ? ACCESS : IDLE) :
             r_state == ACCESS ? (w_last ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_owner <= w_grant_data;
        r_addr  <= w_grant_data ? data_addr : fetch_addr;
        r_we    <= w_grant_data & data_we;
        r_wdata <= w_grant_data ? data_wdata : r_wdata;
        r_cnt   <= '0;
      end
      if (r_state == ACCESS) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last && !r_we) r_rdata <= mem_rdata;
      end
    end
  // Write strobe is gated by state so reset removes it without waiting for a clock.
  assign MemReadWrite = (r_state == ACCESS) & r_we;
  assign Address      = r_addr;
  assign WriteDataMem = r_wdata;
  assign rdata        = r_rdata;
  assign fetch_done   = (r_state == DONE) & ~r_owner;
  assign data_done    = (r_state == DONE) & r_owner;
  assign owner_data   = (r_state != IDLE) & r_owner;
  assign busy         = r_state != IDLE;
  assign State_out    = r_state;
endmodule
